// File: rtl/operand_reader.sv
// Register-read stage: owns the integer register file, bypasses same-cycle writebacks,
// stalls on pending writes via a busy scoreboard, and presents operands through a registered output.
module operand_reader #(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [4:0]           IN_RS1,
    input  logic [4:0]           IN_RS2,
    input  logic [4:0]           IN_RD,
    input  logic                 IN_RD_WRITE,
    input  logic [TAG_WIDTH-1:0] IN_TAG,
    input  logic                 WB_ENABLE,
    input  logic [4:0]           WB_RD,
    input  logic [XLEN-1:0]      WB_DATA,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [XLEN-1:0]      OUT_RS1_DATA,
    output logic [XLEN-1:0]      OUT_RS2_DATA,
    output logic [4:0]           OUT_RD,
    output logic                 OUT_RD_WRITE,
    output logic [TAG_WIDTH-1:0] OUT_TAG
);

    localparam int NREG = 32;

    logic [XLEN-1:0]      rf_q [NREG];
    logic [XLEN-1:0]      rf_d [NREG];
    logic [NREG-1:0]      busy_q, busy_d;
    logic                 out_valid_q, out_valid_d;
    logic [XLEN-1:0]      out_rs1_q, out_rs1_d;
    logic [XLEN-1:0]      out_rs2_q, out_rs2_d;
    logic [4:0]           out_rd_q, out_rd_d;
    logic                 out_rd_write_q, out_rd_write_d;
    logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;

    logic            rs1_hit, rs2_hit, rd_hit;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            stall, in_ready, fire;

    // A writeback to x0 never counts as a hit, so x0 never bypasses a nonzero value.
    assign rs1_hit = WB_ENABLE && (WB_RD == IN_RS1) && (IN_RS1 != 5'd0);
    assign rs2_hit = WB_ENABLE && (WB_RD == IN_RS2) && (IN_RS2 != 5'd0);
    assign rd_hit  = WB_ENABLE && (WB_RD == IN_RD)  && (IN_RD  != 5'd0);

    assign rs1_val = rs1_hit ? WB_DATA : rf_q[IN_RS1];
    assign rs2_val = rs2_hit ? WB_DATA : rf_q[IN_RS2];

    assign stall = (busy_q[IN_RS1] && !rs1_hit)
                || (busy_q[IN_RS2] && !rs2_hit)
                || (IN_RD_WRITE && busy_q[IN_RD] && !rd_hit);

    assign in_ready = (!out_valid_q || OUT_READY) && !stall;
    assign fire     = IN_VALID && in_ready;

    always_comb begin
        // NOTE: every variable gets a default before any conditional update so no latch is inferred.
        rf_d           = rf_q;
        busy_d         = busy_q;
        out_valid_d    = out_valid_q;
        out_rs1_d      = out_rs1_q;
        out_rs2_d      = out_rs2_q;
        out_rd_d       = out_rd_q;
        out_rd_write_d = out_rd_write_q;
        out_tag_d      = out_tag_q;

        if (WB_ENABLE) begin
            rf_d[WB_RD]   = WB_DATA;
            busy_d[WB_RD] = 1'b0;
        end
        // Set after clear so an issue that targets the register being written back stays pending.
        if (fire && IN_RD_WRITE) begin
            busy_d[IN_RD] = 1'b1;
        end
        rf_d[0]   = '0;
        busy_d[0] = 1'b0;

        if (fire) begin
            out_valid_d    = 1'b1;
            out_rs1_d      = rs1_val;
            out_rs2_d      = rs2_val;
            out_rd_d       = IN_RD;
            out_rd_write_d = IN_RD_WRITE;
            out_tag_d      = IN_TAG;
        end else if (OUT_READY) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            // NOTE: the register file is reset because software relies on every register reading 0 after reset.
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
            busy_q         <= '0;
            out_valid_q    <= 1'b0;
            out_rs1_q      <= '0;
            out_rs2_q      <= '0;
            out_rd_q       <= '0;
            out_rd_write_q <= 1'b0;
            out_tag_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            rf_q           <= rf_d;
            busy_q         <= busy_d;
            out_valid_q    <= out_valid_d;
            out_rs1_q      <= out_rs1_d;
            out_rs2_q      <= out_rs2_d;
            out_rd_q       <= out_rd_d;
            out_rd_write_q <= out_rd_write_d;
            out_tag_q      <= out_tag_d;
        end
    end

    assign IN_READY     = in_ready;
    assign OUT_VALID    = out_valid_q;
    assign OUT_RS1_DATA = out_rs1_q;
    assign OUT_RS2_DATA = out_rs2_q;
    assign OUT_RD       = out_rd_q;
    assign OUT_RD_WRITE = out_rd_write_q;
    assign OUT_TAG      = out_tag_q;

endmodule

// File: doc/operand_reader.md
Name: operand_reader

Overview:
Register-read stage, the read-side counterpart of the writeback stage. It owns the 32-entry integer register file and accepts writebacks. It reads rs1/rs2 for each decoded instruction, with same-cycle writeback bypass, and tracks pending destination writes in a scoreboard so RAW/WAW hazards stall issue. Operands are delivered to execute through a registered valid/ready output stage.

Parameters:
XLEN, 32, register and operand width
TAG_WIDTH, 32, width of opaque payload (PC/control) passed decode->execute unchanged

Ports:
CLK  input  1  clock, rising edge
RSTN  input  1  reset, asynchronous, active-low
IN_VALID  input  1  decode offers an instruction
IN_READY  output  1  stage accepts the instruction this cycle
IN_RS1  input  5  source register 1 index
IN_RS2  input  5  source register 2 index
IN_RD  input  5  destination register index
IN_RD_WRITE  input  1  instruction will write IN_RD at writeback
IN_TAG  input  TAG_WIDTH  payload
WB_ENABLE  input  1  writeback strobe
WB_RD  input  5  writeback register index
WB_DATA  input  XLEN  writeback data
OUT_VALID  output  1  operands valid to execute
OUT_READY  input  1  execute accepts
OUT_RS1_DATA  output  XLEN  operand 1
OUT_RS2_DATA  output  XLEN  operand 2
OUT_RD  output  5  registered IN_RD
OUT_RD_WRITE  output  1  registered IN_RD_WRITE
OUT_TAG  output  TAG_WIDTH  registered IN_TAG

Behaviour:
- Reset (RSTN=0, async): all 32 registers=0, scoreboard busy[31:0]=0, OUT_VALID=0, all OUT_* data=0. Reset mid-operation discards the held output and all pending marks immediately. After release: IN_READY=1 when no hazard.
- Register file: write at posedge when WB_ENABLE && WB_RD!=0. Writes to x0 are ignored. x0 always reads 0.
- Writeback to a non-busy register still writes the register file. No error is raised.
- wb_hit(r) = WB_ENABLE && WB_RD==r && r!=0.
- Operand read (combinational, captured at fire): if wb_hit(rs) then WB_DATA, else regfile[rs]. rs=0 gives 0.
- Hazard(r) = busy[r] && !wb_hit(r). A writeback in the same cycle resolves it, and the bypass supplies the data.
- stall = Hazard(IN_RS1) || Hazard(IN_RS2) || (IN_RD_WRITE && Hazard(IN_RD)). busy[0] is constant 0.
- IN_READY = (!OUT_VALID || OUT_READY) && !stall. IN_READY is combinational on IN_RS*/IN_RD*/WB_*/OUT_READY and does not depend on IN_VALID.
- fire = IN_VALID && IN_READY.
- On fire: OUT_* are loaded at the next posedge and OUT_VALID<=1. Latency is 1 cycle.
- No fire and OUT_READY=1: OUT_VALID<=0, and data outputs hold their last value.
- While OUT_VALID && !OUT_READY: all OUT_* hold stable.
- Scoreboard on fire with IN_RD_WRITE && IN_RD!=0: set busy[IN_RD].
- Scoreboard on WB_ENABLE: clear busy[WB_RD].
- Scoreboard set and clear of the same index in the same cycle: set wins.
- At most one pending writer per register, which the WAW stall guarantees.
- Simultaneous writeback to rs1 and rs2 (rs1==rs2): both operands take WB_DATA.

Test Plan:
- Reset, WB x1=0x11 then x2=0x22, then issue rs1=1 rs2=2 with OUT_READY=1 -> next cycle OUT_VALID=1, OUT_RS1_DATA=0x11, OUT_RS2_DATA=0x22; OUT_VALID=0 the cycle after if nothing else issues.
- Issue rs1=5 in the same cycle as WB x5=0xDEADBEEF (x5 previously 0) -> OUT_RS1_DATA=0xDEADBEEF.
- Issue rd=3 with IN_RD_WRITE=1, then offer rs1=3 -> IN_READY=0 for every cycle until WB x3=0x33. In that cycle IN_READY=1, and OUT_RS1_DATA=0x33 the next cycle. Then busy[3]=0.
- WB x0=0xFFFF, then issue rs1=0 rd=0 with IN_RD_WRITE=1, then issue rs1=0 -> no stall, OUT_RS1_DATA=0, busy[0] stays 0.
- Hold OUT_VALID=1 with OUT_READY=0 for 3 cycles -> IN_READY=0 and OUT_* unchanged. Then OUT_READY=1 with a new valid instruction -> fire the same cycle, OUT_VALID stays 1 with the new data.
- Set busy[3] and OUT_VALID=1, then pulse RSTN=0 mid-cycle -> OUT_VALID=0 and registers zero without waiting for a clock edge. After release, rs1=3 issues without stall.
